// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - size encodings, state type and store lane helpers for riscv_lsu.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Half enables are shifted in 8 bits so that offset 3 simply drops the upper lane.
    function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
        logic [7:0] wide;
        wide = 8'h0;
        case (size)
            LDST_B, LDST_BU: wide = 8'b0000_0001 << off;
            LDST_H, LDST_HU: wide = 8'b0000_0011 << off;
            default:         wide = 8'b0000_1111;
        endcase
        return wide[3:0];
    endfunction

    function automatic logic [31:0] store_wd(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] res;
        case (size)
            LDST_B, LDST_BU: res = {4{wd[7:0]}};
            LDST_H, LDST_HU: res = {2{wd[15:0]}};
            default:         res = wd;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic res;
        case (size)
            LDST_B, LDST_BU: res = 1'b0;
            LDST_H, LDST_HU: res = off[0];
            default:         res = (off != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/riscv_lsu_extend.sv
// rtl/riscv_lsu_extend.sv - load lane select and sign/zero extension (combinational).
module riscv_lsu_extend
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (size)
            LDST_B:  result = {{24{shifted[7]}}, shifted[7:0]};
            LDST_BU: result = {24'h0, shifted[7:0]};
            LDST_H:  result = {{16{shifted[15]}}, shifted[15:0]};
            LDST_HU: result = {16'h0, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - single-outstanding load/store unit; LSU_MISALIGN_CHECK_EN adds misaligned trapping.
module riscv_lsu
    import riscv_lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic        misaligned_o,
`endif
    input  logic        mem_ready_i
);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;
    logic [31:0] rdata_q;
    logic [31:0] ext_result;
    logic        capture;
    logic        rd_valid;

    assign capture = (state_q == IDLE) && core_req_i;

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_now;
    logic mis_q;
    assign mis_now      = is_misaligned(core_size_i, core_addr_i[1:0]);
    assign misaligned_o = (state_q == DONE) && mis_q;
    assign rd_valid     = (state_q == DONE) && !we_q && !mis_q;
`else
    assign rd_valid     = (state_q == DONE) && !we_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef LSU_MISALIGN_CHECK_EN
                if (core_req_i) state_d = mis_now ? DONE : REQ;
`else
                if (core_req_i) state_d = REQ;
`endif
            end
            REQ:     if (mem_ready_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane enables and replicated data are resolved at capture so mem_* come straight from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wd_q    <= 32'h0;
            rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (capture) begin
                we_q   <= core_we_i;
                size_q <= core_size_i;
                addr_q <= core_addr_i;
                be_q   <= core_we_i ? store_be(core_size_i, core_addr_i[1:0]) : 4'hF;
                wd_q   <= store_wd(core_size_i, core_wd_i);
`ifdef LSU_MISALIGN_CHECK_EN
                mis_q  <= mis_now;
`endif
            end
            if ((state_q == REQ) && mem_ready_i && !we_q) begin
                rdata_q <= mem_rd_i;
            end
        end
    end

    riscv_lsu_extend u_extend (
        .rdata  (rdata_q),
        .size   (size_q),
        .off    (addr_q[1:0]),
        .result (ext_result)
    );

    assign core_stall_o = core_req_i && (state_q != DONE);
    assign core_rd_o    = rd_valid ? ext_result : 32'h0;
    assign mem_req_o    = (state_q == REQ);
    assign mem_we_o     = we_q;
    assign mem_be_o     = be_q;
    assign mem_addr_o   = {addr_q[31:2], 2'b00};
    assign mem_wd_o     = wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed vector bench for riscv_lsu.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        misaligned_o;
`endif

    always #5 clk_i = ~clk_i;

    riscv_lsu dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
`ifdef LSU_MISALIGN_CHECK_EN
        .misaligned_o (misaligned_o),
`endif
        .mem_ready_i  (mem_ready_i)
    );

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          waits;
        logic        mis;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eaddr;
        logic [31:0] erd;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_access(input vec_t v, output logic [31:0] rd, output logic [3:0] be,
                              output logic [31:0] wd, output logic [31:0] addr, output logic we,
                              output int stalls, output int reqs, output int mis_cnt,
                              output logic stable);
        logic done;
        rd = 0; be = 0; wd = 0; addr = 0; we = 0;
        stalls = 0; reqs = 0; mis_cnt = 0; stable = 1'b1; done = 1'b0;
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = v.we;
        core_size_i = v.size;
        core_addr_i = v.addr;
        core_wd_i   = v.wd;
        mem_rd_i    = v.mrd;
        mem_ready_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
`ifdef LSU_MISALIGN_CHECK_EN
            mis_cnt += int'(misaligned_o);
`endif
            if (!core_stall_o) begin
                rd   = core_rd_o;
                done = 1'b1;
                break;
            end
            stalls++;
            if (mem_req_o) begin
                if (reqs == 0) begin
                    be = mem_be_o; wd = mem_wd_o; addr = mem_addr_o; we = mem_we_o;
                end else if (mem_addr_o !== addr || mem_be_o !== be || mem_wd_o !== wd) begin
                    stable = 1'b0;
                end
                mem_ready_i = (reqs == v.waits);
                reqs++;
            end else begin
                mem_ready_i = 1'b0;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL access_timeout: got stall still high after 40 cycles, want release");
        end
        @(posedge clk_i); #1;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis_cnt += int'(misaligned_o);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, wd, addr;
        logic [3:0]  be;
        logic        we, stable;
        int          stalls, reqs, mis_cnt, cnt;

        //                 we  size   addr          wd            mrd          w  mis be     ewd           eaddr         erd
        vecs[0]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'hF, 32'h0,        32'h0000_0100, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_0011, 0, 1'b0, 4'hF, 32'h0,        32'h0000_0100, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_0011, 1, 1'b0, 4'hF, 32'h0,        32'h0000_0100, 32'h0000_0080};
        vecs[3]  = '{1'b0, 3'd1, 32'h0000_0102, 32'h0,        32'h80FF_0011, 0, 1'b0, 4'hF, 32'h0,        32'h0000_0100, 32'hFFFF_80FF};
        vecs[4]  = '{1'b0, 3'd5, 32'h0000_0102, 32'h0,        32'h80FF_0011, 2, 1'b0, 4'hF, 32'h0,        32'h0000_0100, 32'h0000_80FF};
        vecs[5]  = '{1'b0, 3'd0, 32'h0000_0102, 32'h0,        32'h80FF_0011, 0, 1'b0, 4'hF, 32'h0,        32'h0000_0100, 32'hFFFF_FFFF};
        vecs[6]  = '{1'b0, 3'd4, 32'h0000_0100, 32'h0,        32'h80FF_0011, 0, 1'b0, 4'hF, 32'h0,        32'h0000_0100, 32'h0000_0011};
        vecs[7]  = '{1'b1, 3'd1, 32'h0000_0102, 32'h1234_ABCD, 32'h5555_5555, 1, 1'b0, 4'hC, 32'hABCD_ABCD, 32'h0000_0100, 32'h0};
        vecs[8]  = '{1'b1, 3'd0, 32'h0000_0101, 32'h0000_00A5, 32'h5555_5555, 0, 1'b0, 4'h2, 32'hA5A5_A5A5, 32'h0000_0100, 32'h0};
        vecs[9]  = '{1'b1, 3'd2, 32'h0000_0204, 32'hCAFE_F00D, 32'h5555_5555, 0, 1'b0, 4'hF, 32'hCAFE_F00D, 32'h0000_0204, 32'h0};
        vecs[10] = '{1'b0, 3'd3, 32'h0000_0208, 32'h0,        32'h1234_5678, 0, 1'b0, 4'hF, 32'h0,        32'h0000_0208, 32'h1234_5678};
        vecs[11] = '{1'b1, 3'd1, 32'h0000_0203, 32'h0000_BEEF, 32'h5555_5555, 0, 1'b1, 4'h8, 32'hBEEF_BEEF, 32'h0000_0200, 32'h0};
        vecs[12] = '{1'b0, 3'd2, 32'h0000_0102, 32'h0,        32'hA1B2_C3D4, 0, 1'b1, 4'hF, 32'h0,        32'h0000_0100, 32'hA1B2_C3D4};
        vecs[13] = '{1'b0, 3'd2, 32'h0000_0400, 32'h0,        32'h0F0F_0F0F, 3, 1'b0, 4'hF, 32'h0,        32'h0000_0400, 32'h0F0F_0F0F};

        rst_ni = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
        core_addr_i = 32'h0; core_wd_i = 32'h0; mem_rd_i = 32'h0; mem_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_mem_req", 32'(mem_req_o), 32'h0);
        check("rst_mem_we", 32'(mem_we_o), 32'h0);
        check("rst_mem_be", 32'(mem_be_o), 32'h0);
        check("rst_core_rd", core_rd_o, 32'h0);
        check("rst_stall", 32'(core_stall_o), 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        check("rst_misaligned", 32'(misaligned_o), 32'h0);
`endif
        rst_ni = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_access(vecs[i], rd, be, wd, addr, we, stalls, reqs, mis_cnt, stable);
`ifdef LSU_MISALIGN_CHECK_EN
            if (vecs[i].mis) begin
                check($sformatf("v%0d_mis_reqs", i), 32'(reqs), 32'h0);
                check($sformatf("v%0d_mis_stall", i), 32'(stalls), 32'd1);
                check($sformatf("v%0d_mis_pulse", i), 32'(mis_cnt), 32'd1);
                check($sformatf("v%0d_mis_rd", i), rd, 32'h0);
            end else begin
                check($sformatf("v%0d_mis_none", i), 32'(mis_cnt), 32'h0);
`else
            begin
`endif
                check($sformatf("v%0d_be", i), 32'(be), 32'(vecs[i].ebe));
                check($sformatf("v%0d_wd", i), wd, vecs[i].ewd);
                check($sformatf("v%0d_addr", i), addr, vecs[i].eaddr);
                check($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].we));
                check($sformatf("v%0d_rd", i), rd, vecs[i].erd);
                check($sformatf("v%0d_stall", i), 32'(stalls), 32'(vecs[i].waits + 2));
                check($sformatf("v%0d_reqs", i), 32'(reqs), 32'(vecs[i].waits + 1));
                check($sformatf("v%0d_stable", i), 32'(stable), 32'h1);
            end
            check($sformatf("v%0d_idle_rd", i), core_rd_o, 32'h0);
        end

        // A request held high through DONE must re-enter via IDLE, not straight into REQ.
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h0000_0300; mem_rd_i = 32'h1357_9BDF;
        @(negedge clk_i);
        @(negedge clk_i);
        check("hold_req_up", 32'(mem_req_o), 32'h1);
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        check("hold_done_rd", core_rd_o, 32'h1357_9BDF);
        check("hold_done_stall", 32'(core_stall_o), 32'h0);
        @(negedge clk_i);
        check("hold_idle_req", 32'(mem_req_o), 32'h0);
        check("hold_idle_stall", 32'(core_stall_o), 32'h1);
        @(negedge clk_i);
        check("hold_new_req", 32'(mem_req_o), 32'h1);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        core_req_i = 1'b0; mem_ready_i = 1'b0;

        // Reset mid-REQ drops the access and it is never reissued.
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_addr_i = 32'h0000_0500; mem_rd_i = 32'hFFFF_0000;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rstmid_req_up", 32'(mem_req_o), 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        check("rstmid_req_low", 32'(mem_req_o), 32'h0);
        check("rstmid_be_low", 32'(mem_be_o), 32'h0);
        core_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        mem_ready_i = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk_i);
            cnt += int'(mem_req_o);
        end
        check("rstmid_no_reissue", 32'(cnt), 32'h0);
        check("rstmid_idle_rd", core_rd_o, 32'h0);
        mem_ready_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed at 32-bit data/address and 4-bit byte-enable.
REQ-002 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_ni  in  1  asynchronous, active-low reset.
REQ-004 core_req_i  in  1  memory instruction present in the current core cycle.
REQ-005 core_we_i  in  1  1 = store, 0 = load.
REQ-006 core_size_i  in  3  funct3 encoding: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
REQ-007 core_addr_i  in  32  byte address.
REQ-008 core_wd_i  in  32  store data, right-aligned.
REQ-009 core_rd_o  out  32  load result, extended, destined for the register file write port.
REQ-010 core_stall_o  out  1  core holds PC and all core_* inputs stable while this is high.
REQ-011 mem_req_o  out  1  memory request, registered.
REQ-012 mem_we_o  out  1  store strobe, registered.
REQ-013 mem_be_o  out  4  byte enables, registered.
REQ-014 mem_addr_o  out  32  word address: {addr[31:2], 2'b00}, registered.
REQ-015 mem_wd_o  out  32  lane-replicated store data, registered.
REQ-016 mem_rd_i  in  32  read word from memory.
REQ-017 mem_ready_i  in  1  memory completes the request in this cycle.
REQ-018 misaligned_o  out  1  misalignment pulse; present only when LSU_MISALIGN_CHECK_EN is defined.

Function
REQ-019 FSM states SHALL be IDLE, REQ and DONE.
REQ-020 Transitions SHALL be IDLE->REQ on core_req_i; REQ->DONE on mem_ready_i; DONE->IDLE unconditionally.
REQ-021 On IDLE->REQ the request (we, size, addr[1:0], addr, wd) SHALL be captured into registers; mem_* outputs SHALL be driven from these registers.
REQ-022 mem_req_o SHALL be 1 exactly while in REQ and held until mem_ready_i is sampled high.
REQ-023 core_stall_o SHALL equal core_req_i AND (state != DONE), combinationally.
REQ-024 Minimum latency SHALL be request at cycle 0, ready at cycle 1, stall low in cycle 2; each extra wait cycle SHALL add one cycle.
REQ-025 On REQ->DONE with a load, mem_rd_i SHALL be latched.
REQ-026 core_rd_o SHALL select the byte or half lane at offset addr[1:0], then apply the extension:
- B/H: sign-extended.
- BU/HU: zero-extended.
- W: passed through.
REQ-027 core_rd_o SHALL be 0 outside DONE and for stores.
REQ-028 Store byte enables SHALL be:
- B: 4'b0001 << off.
- H: 4'b0011 << off, truncated to 4 bits.
- W: 4'b1111.
REQ-029 Store data SHALL be replicated across lanes:
- B: {4{wd[7:0]}}.
- H: {2{wd[15:0]}}.
- W: wd.
REQ-030 For loads, mem_be_o SHALL be 4'b1111 and mem_we_o SHALL be 0.
REQ-031 Unsupported sizes (3, 6, 7) SHALL behave as W.
REQ-032 mem_ready_i SHALL be ignored outside REQ.
REQ-033 A core_req_i arriving in DONE SHALL NOT start a new access; the next access starts from IDLE.

Reset
REQ-034 Asserting rst_ni low SHALL, at any time including mid-REQ, force IDLE and clear all registers to 0.
REQ-035 During reset, mem_req_o, mem_we_o, mem_be_o, core_rd_o and misaligned_o SHALL be 0.
REQ-036 An in-flight request aborted by reset SHALL be dropped and never reissued.

Configuration
REQ-037 With LSU_MISALIGN_CHECK_EN defined, an access SHALL be misaligned when H/HU has addr[0]=1, or W has addr[1:0]!=0.
REQ-038 A misaligned access SHALL go IDLE->DONE directly, issue no mem_req_o, and pulse misaligned_o high for the DONE cycle, with core_rd_o=0.
REQ-039 Without LSU_MISALIGN_CHECK_EN, the misaligned_o port SHALL be absent and accesses SHALL proceed per REQ-028, with truncated byte enables.

Structure
REQ-040 Package riscv_lsu_pkg SHALL hold the size encodings (LDST_B/H/W/BU/HU) and the state enum type.
REQ-041 Load lane-select and extension SHALL be a combinational sub-module, riscv_lsu_extend.

Verification
REQ-042 Scenario 1: LW at 0x100; mem_rd_i=0xDEADBEEF with ready in the first REQ cycle -> core_rd_o=0xDEADBEEF; stall high for exactly 2 cycles.
REQ-043 Scenario 2: LB at 0x103 with mem_rd_i=0x80FF0011 -> core_rd_o=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-044 Scenario 3: SH at 0x102 with wd=0x1234ABCD -> mem_be_o=4'b1100, mem_wd_o=0xABCDABCD, mem_addr_o=0x100, mem_we_o=1.
REQ-045 Scenario 4: LW with ready delayed 3 cycles -> mem_req_o held 4 cycles, address stable throughout, stall released one cycle after ready.
REQ-046 Scenario 5: rst_ni dropped during REQ -> mem_req_o=0 immediately; after release, IDLE with no reissue.
REQ-047 Scenario 6 (macro defined): LW at 0x102 -> no mem_req_o, misaligned_o one-cycle pulse, stall high for 1 cycle.
